writeback_arbiter: RTL and testbench

- Write-side front end of the 4-entry, 16-bit CPU register file.
- Accepts results from two producers over valid/ready handshakes: the ALU and the load/memory unit.
- Each producer has a one-entry holding buffer. The block arbitrates round-robin between them and drives a registered single-port write (write_enable / write_reg_num / write_data) into the register file.
- Keeps a pending-register scoreboard that decode uses to stall on unresolved destinations.

---
 rtl/writeback_arbiter.sv | 120 ++++++++++++
 tb/tb_writeback_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Register-file write front end: two one-entry result buffers (ALU, load),
// round-robin arbitration onto a registered write port, and a pending-register scoreboard.
module writeback_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [REG_ADDR_WIDTH-1:0]    alu_reg,
  input  logic [DATA_WIDTH-1:0]        alu_data,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [REG_ADDR_WIDTH-1:0]    mem_reg,
  input  logic [DATA_WIDTH-1:0]        mem_data,
  input  logic                         reserve_valid,
  input  logic [REG_ADDR_WIDTH-1:0]    reserve_reg,
  output logic                         write_enable,
  output logic [REG_ADDR_WIDTH-1:0]    write_reg_num,
  output logic [DATA_WIDTH-1:0]        write_data,
  output logic [2**REG_ADDR_WIDTH-1:0] busy_mask
);

  localparam int NREG = 2**REG_ADDR_WIDTH;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  logic                      alu_full_q, alu_full_d;
  logic [REG_ADDR_WIDTH-1:0] alu_reg_q, alu_reg_d;
  logic [DATA_WIDTH-1:0]     alu_data_q, alu_data_d;
  logic                      mem_full_q, mem_full_d;
  logic [REG_ADDR_WIDTH-1:0] mem_reg_q, mem_reg_d;
  logic [DATA_WIDTH-1:0]     mem_data_q, mem_data_d;
  src_e                      last_grant_q, last_grant_d;
  logic [NREG-1:0]           pending_q, pending_d;
  logic                      write_enable_q, write_enable_d;
  logic [REG_ADDR_WIDTH-1:0] write_reg_num_q, write_reg_num_d;
  logic [DATA_WIDTH-1:0]     write_data_q, write_data_d;

  logic                      grant_alu, grant_mem, grant_any;
  logic                      alu_take, mem_take;
  logic [REG_ADDR_WIDTH-1:0] gnt_reg;
  logic [DATA_WIDTH-1:0]     gnt_data;
  logic [NREG-1:0]           clr_mask, set_mask;

  always_comb begin
    // With both buffers full the source that did not win last time goes first.
    grant_alu = alu_full_q & (!mem_full_q | (last_grant_q == SRC_MEM));
    grant_mem = mem_full_q & (!alu_full_q | (last_grant_q == SRC_ALU));
    grant_any = grant_alu | grant_mem;
    gnt_reg   = grant_mem ? mem_reg_q  : alu_reg_q;
    gnt_data  = grant_mem ? mem_data_q : alu_data_q;

    // Ready depends only on buffer state, so a draining buffer refills on the same edge.
    alu_ready = reset & (!alu_full_q | grant_alu);
    mem_ready = reset & (!mem_full_q | grant_mem);
    alu_take  = alu_valid & alu_ready;
    mem_take  = mem_valid & mem_ready;

    alu_full_d = alu_take | (alu_full_q & !grant_alu);
    alu_reg_d  = alu_take ? alu_reg  : alu_reg_q;
    alu_data_d = alu_take ? alu_data : alu_data_q;
    mem_full_d = mem_take | (mem_full_q & !grant_mem);
    mem_reg_d  = mem_take ? mem_reg  : mem_reg_q;
    mem_data_d = mem_take ? mem_data : mem_data_q;

    last_grant_d = last_grant_q;
    if (grant_alu) last_grant_d = SRC_ALU;
    if (grant_mem) last_grant_d = SRC_MEM;

    // A reservation on the same edge as the clearing write keeps the register pending.
    clr_mask = '0;
    set_mask = '0;
    if (grant_any)     clr_mask[gnt_reg]     = 1'b1;
    if (reserve_valid) set_mask[reserve_reg] = 1'b1;
    pending_d = (pending_q & ~clr_mask) | set_mask;

    write_enable_d  = grant_any;
    write_reg_num_d = grant_any ? gnt_reg  : write_reg_num_q;
    write_data_d    = grant_any ? gnt_data : write_data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_full_q      <= 1'b0;
      mem_full_q      <= 1'b0;
      last_grant_q    <= SRC_ALU;
      pending_q       <= '0;
      write_enable_q  <= 1'b0;
      write_reg_num_q <= '0;
      write_data_q    <= '0;
    end else begin
      alu_full_q      <= alu_full_d;
      mem_full_q      <= mem_full_d;
      last_grant_q    <= last_grant_d;
      pending_q       <= pending_d;
      write_enable_q  <= write_enable_d;
      write_reg_num_q <= write_reg_num_d;
      write_data_q    <= write_data_d;
    end
  end

  // Buffer payloads are qualified by the full flags and need no reset.
  always_ff @(posedge clk) begin
    alu_reg_q  <= alu_reg_d;
    alu_data_q <= alu_data_d;
    mem_reg_q  <= mem_reg_d;
    mem_data_q <= mem_data_d;
  end

  assign write_enable  = write_enable_q;
  assign write_reg_num = write_reg_num_q;
  assign write_data    = write_data_q;
  assign busy_mask     = pending_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: a transaction-level model predicts
// ready, write order/timing and the pending mask; a negedge monitor checks writes.
module tb_writeback_arbiter;

  localparam int DW = 16;
  localparam int AW = 2;

  logic          clk;
  logic          reset;
  logic          alu_valid, mem_valid, reserve_valid;
  logic          alu_ready, mem_ready;
  logic [AW-1:0] alu_reg, mem_reg, reserve_reg;
  logic [DW-1:0] alu_data, mem_data;
  logic          write_enable;
  logic [AW-1:0] write_reg_num;
  logic [DW-1:0] write_data;
  logic [3:0]    busy_mask;

  writeback_arbiter #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .reserve_valid(reserve_valid), .reserve_reg(reserve_reg),
    .write_enable(write_enable), .write_reg_num(write_reg_num), .write_data(write_data),
    .busy_mask(busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int reg_num;
    int data;
    int cyc;
  } wr_t;

  wr_t exp_q[$];
  wr_t alu_buf[$];
  wr_t mem_buf[$];
  int  last_src;   // 0 = ALU won last, 1 = MEM won last
  bit  pend[4];
  int  cyc;
  int  n_cmp;
  int  n_bad;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int pend_mask();
    int m = 0;
    for (int i = 0; i < 4; i++) if (pend[i]) m |= (1 << i);
    return m;
  endfunction

  // Monitor: a write is expected exactly on the cycle the model granted it.
  always @(negedge clk) begin
    bit exp_we;
    exp_we = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    chk("write_enable", int'(write_enable), int'(exp_we));
    if (exp_we && write_enable) begin
      chk("write_reg_num", int'(write_reg_num), exp_q[0].reg_num);
      chk("write_data", int'(write_data), exp_q[0].data);
    end
    if (exp_we) void'(exp_q.pop_front());
    chk("busy_mask", int'(busy_mask), pend_mask());
  end

  // One clock of stimulus; called just after a falling edge.
  task automatic cycle(input bit av, input int ar, input int ad,
                       input bit mv, input int mr, input int md,
                       input bit rv, input int rr);
    int  g;
    bit  a_rdy, m_rdy;
    wr_t w;
    alu_valid = av; alu_reg = AW'(ar); alu_data = DW'(ad);
    mem_valid = mv; mem_reg = AW'(mr); mem_data = DW'(md);
    reserve_valid = rv; reserve_reg = AW'(rr);
    #1;
    if (alu_buf.size() > 0 && mem_buf.size() > 0) g = (last_src == 0) ? 2 : 1;
    else if (alu_buf.size() > 0) g = 1;
    else if (mem_buf.size() > 0) g = 2;
    else g = 0;
    a_rdy = (alu_buf.size() == 0) || (g == 1);
    m_rdy = (mem_buf.size() == 0) || (g == 2);
    chk("alu_ready", int'(alu_ready), int'(a_rdy));
    chk("mem_ready", int'(mem_ready), int'(m_rdy));
    @(posedge clk);
    cyc++;
    if (g != 0) begin
      w = (g == 1) ? alu_buf.pop_front() : mem_buf.pop_front();
      w.cyc = cyc;
      exp_q.push_back(w);
      pend[w.reg_num] = 1'b0;
      last_src = g - 1;
    end
    if (av && a_rdy) begin w.reg_num = ar; w.data = ad & 16'hFFFF; w.cyc = 0; alu_buf.push_back(w); end
    if (mv && m_rdy) begin w.reg_num = mr; w.data = md & 16'hFFFF; w.cyc = 0; mem_buf.push_back(w); end
    if (rv) pend[rr] = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_clear();
    exp_q.delete(); alu_buf.delete(); mem_buf.delete();
    last_src = 0;
    for (int i = 0; i < 4; i++) pend[i] = 1'b0;
  endtask

  // Asserts reset between edges, checks the asynchronous effect, releases after one edge.
  task automatic reset_pulse();
    alu_valid = 0; mem_valid = 0; reserve_valid = 0;
    #2 reset = 1'b0;
    #1;
    chk("rst_write_enable", int'(write_enable), 0);
    chk("rst_alu_ready", int'(alu_ready), 0);
    chk("rst_mem_ready", int'(mem_ready), 0);
    model_clear();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("rst_busy_mask", int'(busy_mask), 0);
    #1 reset = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    model_clear();
    reset = 1'b0;
    alu_valid = 0; mem_valid = 0; reserve_valid = 0;
    alu_reg = 0; mem_reg = 0; reserve_reg = 0; alu_data = 0; mem_data = 0;
    @(negedge clk);
    chk("init_write_enable", int'(write_enable), 0);
    chk("init_write_reg_num", int'(write_reg_num), 0);
    chk("init_write_data", int'(write_data), 0);
    chk("init_alu_ready", int'(alu_ready), 0);
    @(posedge clk); cyc++;
    @(negedge clk);
    #1 reset = 1'b1;
    idle(2);

    // single ALU transfer
    cycle(1, 2, 16'h1234, 0, 0, 0, 0, 0);
    idle(3);
    // collisions: MEM first after reset, then order alternates
    cycle(1, 1, 16'h00AA, 1, 3, 16'h00BB, 0, 0);
    idle(3);
    cycle(1, 1, 16'h00AA, 1, 3, 16'h00BB, 0, 0);
    idle(3);
    // back-to-back ALU stream
    for (int i = 1; i <= 4; i++) cycle(1, 0, i, 0, 0, 0, 0, 0);
    idle(3);
    // scoreboard: set wins over same-edge clear
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    chk("busy_after_reserve", int'(busy_mask), 4'b0001);
    cycle(0, 0, 0, 1, 0, 16'h5555, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    chk("busy_set_wins", int'(busy_mask), 4'b0001);
    cycle(0, 0, 0, 1, 0, 16'h6666, 0, 0);
    idle(2);
    chk("busy_cleared", int'(busy_mask), 4'b0000);
    // write to a non-pending register
    cycle(1, 3, 16'h7777, 0, 0, 0, 0, 0);
    idle(2);
    // reset while both buffers are full
    cycle(1, 1, 16'h1111, 1, 2, 16'h2222, 1, 1);
    cycle(1, 3, 16'h3333, 1, 0, 16'h4444, 0, 0);
    reset_pulse();
    idle(4);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 65535),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 65535),
            $urandom_range(0, 2) == 0, $urandom_range(0, 3));
      if (i == 250) begin
        reset_pulse();
      end
    end
    idle(5);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
